vc_credit_requester: RTL and testbench

VC_CREDIT_REQUESTER -- requirements
Module: vc_credit_requester

---
 rtl/router_pkg.sv | 18 +
 rtl/vc_credit_requester_if.sv | 43 ++++
 rtl/vc_credit_slice.sv | 85 ++++++++
 rtl/vc_credit_requester.sv | 80 ++++++++
 tb/tb_vc_credit_requester.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Constants shared by the VC credit requester:
//   - default VC count, per-VC buffer depth and downstream credit depth
//   - bit positions of the three error flags in the err vector
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int NUM_REQS_DEF     = 3;
  localparam int BUF_DEPTH_DEF    = 4;
  localparam int CREDIT_DEPTH_DEF = 4;

  localparam int ERR_W       = 3;
  localparam int ERR_GRANT   = 0;
  localparam int ERR_BUF_OVF = 1;
  localparam int ERR_CRD_OVF = 2;

endpackage

// File: rtl/vc_credit_requester_if.sv
// -----------------------------------------------------------------------------
// vc_credit_requester_if
// Bundle between the requester and its environment (flit source, downstream
// credit return, matrix arbiter, status observers).
//   flit_valid    [NUM_REQS]        one flit enqueued per set bit
//   credit_return [NUM_REQS]        one credit returned per set bit
//   grants        [NUM_REQS]        arbiter grant, expected one-hot or zero
//   requests      [NUM_REQS]        request vector to the arbiter
//   credit_cnt    [NUM_REQS*CW]     per-VC credit counters, VC0 in the LSBs
//   pend_cnt      [NUM_REQS*PW]     per-VC pending-flit counters, VC0 in LSBs
//   err           [3]               {credit_overflow, buf_overflow, grant_err}
// Modports: slave = the requester, master = the environment driving it.
// -----------------------------------------------------------------------------
interface vc_credit_requester_if
  import router_pkg::*;
#(
  parameter int NUM_REQS     = NUM_REQS_DEF,
  parameter int BUF_DEPTH    = BUF_DEPTH_DEF,
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF
) ();

  localparam int PW = $clog2(BUF_DEPTH + 1);
  localparam int CW = $clog2(CREDIT_DEPTH + 1);

  logic [NUM_REQS-1:0]    flit_valid;
  logic [NUM_REQS-1:0]    credit_return;
  logic [NUM_REQS-1:0]    grants;
  logic [NUM_REQS-1:0]    requests;
  logic [NUM_REQS*CW-1:0] credit_cnt;
  logic [NUM_REQS*PW-1:0] pend_cnt;
  logic [ERR_W-1:0]       err;

  modport slave (
    input  flit_valid, credit_return, grants,
    output requests, credit_cnt, pend_cnt, err
  );

  modport master (
    output flit_valid, credit_return, grants,
    input  requests, credit_cnt, pend_cnt, err
  );

endinterface

// File: rtl/vc_credit_slice.sv
// -----------------------------------------------------------------------------
// vc_credit_slice
// State of one virtual channel: pending-flit counter, downstream credit
// counter, the arbiter request and this VC's overflow flags.
//   clk, reset       clock, asynchronous active-high reset
//   i_flit_valid     one flit enqueued this cycle
//   i_credit_return  one credit returned this cycle
//   i_grant_acc      grant on this VC accepted by the top level this cycle
//   o_request        pending flit and credit available (from registers only)
//   o_pend_cnt       pending-flit count, 0..BUF_DEPTH
//   o_credit_cnt     credit count, 0..CREDIT_DEPTH
//   o_buf_ovf        flit dropped because the VC is full (combinational)
//   o_crd_ovf        credit returned while already at CREDIT_DEPTH (comb.)
// -----------------------------------------------------------------------------
module vc_credit_slice
  import router_pkg::*;
#(
  parameter int BUF_DEPTH    = BUF_DEPTH_DEF,
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
  localparam int PW          = $clog2(BUF_DEPTH + 1),
  localparam int CW          = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flit_valid,
  input  logic          i_credit_return,
  input  logic          i_grant_acc,
  output logic          o_request,
  output logic [PW-1:0] o_pend_cnt,
  output logic [CW-1:0] o_credit_cnt,
  output logic          o_buf_ovf,
  output logic          o_crd_ovf
);

  localparam logic [PW-1:0] PEND_MAX = PW'(BUF_DEPTH);
  localparam logic [CW-1:0] CRD_MAX  = CW'(CREDIT_DEPTH);

  logic [PW-1:0] r_pend;
  logic [CW-1:0] r_credit;
  logic [PW-1:0] w_pend_nxt;
  logic [CW-1:0] w_credit_nxt;

  // A grant consumes one flit and one credit; an arrival on the same cycle
  // cancels it out, so a full VC or a full credit pool never overflows then.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_pend_nxt   = r_pend;
    w_credit_nxt = r_credit;
    o_buf_ovf    = 1'b0;
    o_crd_ovf    = 1'b0;

    if (i_flit_valid && !i_grant_acc) begin
      if (r_pend == PEND_MAX) o_buf_ovf  = 1'b1;
      else                    w_pend_nxt = r_pend + PW'(1);
    end else if (!i_flit_valid && i_grant_acc) begin
      w_pend_nxt = r_pend - PW'(1);
    end

    if (i_credit_return && !i_grant_acc) begin
      if (r_credit == CRD_MAX) o_crd_ovf    = 1'b1;
      else                     w_credit_nxt = r_credit + CW'(1);
    end else if (!i_credit_return && i_grant_acc) begin
      w_credit_nxt = r_credit - CW'(1);
    end
  end

  // Credits start full: the downstream buffer is empty out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend   <= '0;
      r_credit <= CRD_MAX;
    end else begin
      // NOTE: non-blocking assignments for all registered state so every
      // flop samples pre-edge values regardless of statement order.
      r_pend   <= w_pend_nxt;
      r_credit <= w_credit_nxt;
    end
  end

  assign o_request    = (r_pend != '0) && (r_credit != '0);
  assign o_pend_cnt   = r_pend;
  assign o_credit_cnt = r_credit;

endmodule

// File: rtl/vc_credit_requester.sv
// -----------------------------------------------------------------------------
// vc_credit_requester
// Credit-based request generator for NUM_REQS virtual channels feeding a
// matrix arbiter. Each VC is a vc_credit_slice; this level only qualifies
// the incoming grant and registers the OR-reduced error pulses.
//   clk    clock, all state updates on the rising edge
//   reset  asynchronous active-high reset
//   bus    vc_credit_requester_if.slave (flit_valid, credit_return, grants in;
//          requests, credit_cnt, pend_cnt, err out)
// -----------------------------------------------------------------------------
module vc_credit_requester
  import router_pkg::*;
#(
  parameter int NUM_REQS     = NUM_REQS_DEF,
  parameter int BUF_DEPTH    = BUF_DEPTH_DEF,
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF
) (
  input logic                  clk,
  input logic                  reset,
  vc_credit_requester_if.slave bus
);

  localparam int PW = $clog2(BUF_DEPTH + 1);
  localparam int CW = $clog2(CREDIT_DEPTH + 1);

  logic                         w_onehot;
  logic                         w_legal;
  logic                         w_grant_err;
  logic [NUM_REQS-1:0]          w_grant_acc;
  logic [NUM_REQS-1:0]          w_req;
  logic [NUM_REQS-1:0]          w_buf_ovf;
  logic [NUM_REQS-1:0]          w_crd_ovf;
  logic [NUM_REQS-1:0][PW-1:0]  w_pend;
  logic [NUM_REQS-1:0][CW-1:0]  w_credit;
  logic [ERR_W-1:0]             r_err;

  // x & (x-1) clears the lowest set bit: zero result means at most one bit.
  assign w_onehot    = (bus.grants != '0) &&
                       ((bus.grants & (bus.grants - NUM_REQS'(1))) == '0);
  // A one-hot grant is only honoured on a VC that is actually requesting.
  assign w_legal     = w_onehot && ((bus.grants & w_req) != '0);
  assign w_grant_err = (bus.grants != '0) && !w_legal;
  assign w_grant_acc = w_legal ? bus.grants : '0;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_vc
    vc_credit_slice #(
      .BUF_DEPTH    (BUF_DEPTH),
      .CREDIT_DEPTH (CREDIT_DEPTH)
    ) u_slice (
      .clk             (clk),
      .reset           (reset),
      .i_flit_valid    (bus.flit_valid[gi]),
      .i_credit_return (bus.credit_return[gi]),
      .i_grant_acc     (w_grant_acc[gi]),
      .o_request       (w_req[gi]),
      .o_pend_cnt      (w_pend[gi]),
      .o_credit_cnt    (w_credit[gi]),
      .o_buf_ovf       (w_buf_ovf[gi]),
      .o_crd_ovf       (w_crd_ovf[gi])
    );
  end

  // Error pulses last exactly one cycle: each edge overwrites with the
  // current cycle's flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      r_err[ERR_GRANT]   <= w_grant_err;
      r_err[ERR_BUF_OVF] <= |w_buf_ovf;
      r_err[ERR_CRD_OVF] <= |w_crd_ovf;
    end
  end

  assign bus.requests   = w_req;
  assign bus.pend_cnt   = w_pend;
  assign bus.credit_cnt = w_credit;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_vc_credit_requester.sv
// -----------------------------------------------------------------------------
// tb_vc_credit_requester
// Table of single-cycle vectors with hand-derived expected state, pushed to a
// scoreboard queue when driven and compared after the clock edge, followed by
// hand-written sequences for reset behaviour.
// -----------------------------------------------------------------------------
module tb_vc_credit_requester;

  localparam int NR = 3;
  localparam int BD = 4;
  localparam int CD = 4;
  localparam int NV = 22;

  typedef struct {
    string      name;
    logic [2:0] flit;
    logic [2:0] cret;
    logic [2:0] gnt;
    logic [2:0] req;
    logic [8:0] pend;
    logic [8:0] crd;
    logic [2:0] err;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] req;
    logic [8:0] pend;
    logic [8:0] crd;
    logic [2:0] err;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  vec_t vecs [NV];
  exp_t sb_q [$];

  vc_credit_requester_if #(.NUM_REQS(NR), .BUF_DEPTH(BD), .CREDIT_DEPTH(CD)) bus ();

  vc_credit_requester #(.NUM_REQS(NR), .BUF_DEPTH(BD), .CREDIT_DEPTH(CD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Pack three per-VC counts, VC0 in the LSBs.
  function automatic logic [8:0] pk(input int v0, input int v1, input int v2);
    return {3'(v2), 3'(v1), 3'(v0)};
  endfunction

  function automatic vec_t mk(input string nm, input logic [2:0] f, input logic [2:0] c,
                              input logic [2:0] g, input logic [2:0] r,
                              input logic [8:0] p, input logic [8:0] cr,
                              input logic [2:0] e);
    vec_t v;
    v.name = nm; v.flit = f; v.cret = c; v.gnt = g;
    v.req = r; v.pend = p; v.crd = cr; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_expected(input exp_t e);
    check({e.name, " requests"},   32'(bus.requests),   32'(e.req));
    check({e.name, " pend_cnt"},   32'(bus.pend_cnt),   32'(e.pend));
    check({e.name, " credit_cnt"}, 32'(bus.credit_cnt), 32'(e.crd));
    check({e.name, " err"},        32'(bus.err),        32'(e.err));
  endtask

  task automatic pop_and_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: got empty queue required an expected entry");
    end else begin
      e = sb_q.pop_front();
      compare_expected(e);
    end
  endtask

  initial begin
    exp_t e;
    n_checks = 0;
    n_errors = 0;

    //            name          flit    cret    gnt     req     pend          credit        err
    vecs[0]  = mk("fill_all",   3'b111, 3'b000, 3'b000, 3'b111, pk(1,1,1),   pk(4,4,4),   3'b000);
    vecs[1]  = mk("vc0_g1",     3'b001, 3'b000, 3'b001, 3'b111, pk(1,1,1),   pk(3,4,4),   3'b000);
    vecs[2]  = mk("vc0_g2",     3'b001, 3'b000, 3'b001, 3'b111, pk(1,1,1),   pk(2,4,4),   3'b000);
    vecs[3]  = mk("vc0_g3",     3'b001, 3'b000, 3'b001, 3'b111, pk(1,1,1),   pk(1,4,4),   3'b000);
    vecs[4]  = mk("vc0_g4",     3'b001, 3'b000, 3'b001, 3'b110, pk(1,1,1),   pk(0,4,4),   3'b000);
    vecs[5]  = mk("vc0_nocrd",  3'b001, 3'b000, 3'b000, 3'b110, pk(2,1,1),   pk(0,4,4),   3'b000);
    vecs[6]  = mk("vc0_cret",   3'b000, 3'b001, 3'b000, 3'b111, pk(2,1,1),   pk(1,4,4),   3'b000);
    vecs[7]  = mk("vc1_f2",     3'b010, 3'b000, 3'b000, 3'b111, pk(2,2,1),   pk(1,4,4),   3'b000);
    vecs[8]  = mk("vc1_f3",     3'b010, 3'b000, 3'b000, 3'b111, pk(2,3,1),   pk(1,4,4),   3'b000);
    vecs[9]  = mk("vc1_f4",     3'b010, 3'b000, 3'b000, 3'b111, pk(2,4,1),   pk(1,4,4),   3'b000);
    vecs[10] = mk("vc1_ovf",    3'b010, 3'b000, 3'b000, 3'b111, pk(2,4,1),   pk(1,4,4),   3'b010);
    vecs[11] = mk("vc1_fg",     3'b010, 3'b000, 3'b010, 3'b111, pk(2,4,1),   pk(1,3,4),   3'b000);
    vecs[12] = mk("vc2_drain",  3'b000, 3'b000, 3'b100, 3'b011, pk(2,4,0),   pk(1,3,3),   3'b000);
    vecs[13] = mk("g_multi",    3'b000, 3'b000, 3'b011, 3'b011, pk(2,4,0),   pk(1,3,3),   3'b001);
    vecs[14] = mk("g_clear",    3'b000, 3'b000, 3'b000, 3'b011, pk(2,4,0),   pk(1,3,3),   3'b000);
    vecs[15] = mk("g_noreq",    3'b000, 3'b000, 3'b100, 3'b011, pk(2,4,0),   pk(1,3,3),   3'b001);
    vecs[16] = mk("idle",       3'b000, 3'b000, 3'b000, 3'b011, pk(2,4,0),   pk(1,3,3),   3'b000);
    vecs[17] = mk("vc2_cret",   3'b000, 3'b100, 3'b000, 3'b011, pk(2,4,0),   pk(1,3,4),   3'b000);
    vecs[18] = mk("vc2_crdovf", 3'b000, 3'b100, 3'b000, 3'b011, pk(2,4,0),   pk(1,3,4),   3'b100);
    vecs[19] = mk("multi_ovf",  3'b010, 3'b111, 3'b000, 3'b011, pk(2,4,0),   pk(2,4,4),   3'b110);
    vecs[20] = mk("vc1_gcret",  3'b000, 3'b010, 3'b010, 3'b011, pk(2,3,0),   pk(2,4,4),   3'b000);
    vecs[21] = mk("vc2_flit",   3'b100, 3'b000, 3'b000, 3'b111, pk(2,3,1),   pk(2,4,4),   3'b000);

    bus.flit_valid    = '0;
    bus.credit_return = '0;
    bus.grants        = '0;
    reset             = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    e.name = "reset"; e.req = 3'b000; e.pend = pk(0,0,0); e.crd = pk(4,4,4); e.err = 3'b000;
    compare_expected(e);

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.flit_valid    = vecs[i].flit;
      bus.credit_return = vecs[i].cret;
      bus.grants        = vecs[i].gnt;
      e.name = vecs[i].name; e.req = vecs[i].req; e.pend = vecs[i].pend;
      e.crd  = vecs[i].crd;  e.err = vecs[i].err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      pop_and_compare();
    end

    // Illegal grant raises err[0], then reset lands between edges.
    @(negedge clk);
    bus.flit_valid    = '0;
    bus.credit_return = '0;
    bus.grants        = 3'b011;
    e.name = "pre_rst_gerr"; e.req = 3'b111; e.pend = pk(2,3,1); e.crd = pk(2,4,4); e.err = 3'b001;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pop_and_compare();
    #1;
    reset = 1'b1;
    #1;
    e.name = "async_rst"; e.req = 3'b000; e.pend = pk(0,0,0); e.crd = pk(4,4,4); e.err = 3'b000;
    compare_expected(e);

    // Held reset ignores the still-illegal grant: no error pulse.
    @(posedge clk);
    #1;
    e.name = "rst_held";
    compare_expected(e);

    // First edge with reset low performs the first update.
    @(negedge clk);
    reset          = 1'b0;
    bus.grants     = '0;
    bus.flit_valid = 3'b001;
    @(posedge clk);
    #1;
    e.name = "post_rst"; e.req = 3'b001; e.pend = pk(1,0,0); e.crd = pk(4,4,4); e.err = 3'b000;
    compare_expected(e);

    @(negedge clk);
    bus.flit_valid = '0;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
